// File: rtl/sa_tile_scheduler_if.sv
// sa_tile_scheduler_if: tile request, operand-fetch and result handshake bundle for the tile scheduler
interface sa_tile_scheduler_if #(parameter int MAX_K = 256);
  localparam int KW = $clog2(MAX_K + 1);
  localparam int AW = $clog2(MAX_K);
  logic start;
  logic [KW-1:0] k_len;
  logic abort;
  logic out_ready;
  logic start_ready;
  logic busy;
  logic sa_clear;
  logic rd_en;
  logic [AW-1:0] rd_addr;
  logic feed_valid;
  logic out_valid;
  modport master (
    output start, k_len, abort, out_ready,
    input start_ready, busy, sa_clear, rd_en, rd_addr, feed_valid, out_valid
  );
  modport slave (
    input start, k_len, abort, out_ready,
    output start_ready, busy, sa_clear, rd_en, rd_addr, feed_valid, out_valid
  );
endinterface

// File: rtl/sa_tile_scheduler.sv
// sa_tile_scheduler: sequences clear, operand feed, pipeline drain and result hold for one systolic-array tile
module sa_tile_scheduler #(
  parameter int CONTEXT_LENGTH = 128,
  parameter int HIDDEN_SIZE = 64,
  parameter int MAX_K = 256
) (
  input logic clock,
  input logic rst,
  sa_tile_scheduler_if.slave s
);
  localparam int KW = $clog2(MAX_K + 1);
  localparam int AW = $clog2(MAX_K);
  localparam int DRAIN = CONTEXT_LENGTH + HIDDEN_SIZE;
  localparam int DW = $clog2(DRAIN + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN_S, DONE} state_t;
  state_t state;
  logic [KW-1:0] k_reg;
  logic [DW-1:0] dcnt;
  assign s.start_ready = state == IDLE;
  assign s.busy = state != IDLE;
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      k_reg <= '0;
      dcnt <= '0;
      s.rd_addr <= '0;
      s.rd_en <= 1'b0;
      s.feed_valid <= 1'b0;
      s.sa_clear <= 1'b0;
      s.out_valid <= 1'b0;
    end else if (s.abort && state != IDLE) begin
      state <= IDLE;
      dcnt <= '0;
      s.rd_addr <= '0;
      s.rd_en <= 1'b0;
      s.feed_valid <= 1'b0;
      s.sa_clear <= 1'b0;
      s.out_valid <= 1'b0;
    end else begin
      s.feed_valid <= s.rd_en;
      s.sa_clear <= 1'b0;
      case (state)
        IDLE: if (s.start) begin
          state <= CLEAR;
          k_reg <= s.k_len > KW'(MAX_K) ? KW'(MAX_K) : s.k_len;
          s.sa_clear <= 1'b1;
        end
        CLEAR: begin
          state <= k_reg != '0 ? FEED : DRAIN_S;
          s.rd_en <= k_reg != '0;
          s.rd_addr <= '0;
          dcnt <= DW'(DRAIN - 1);
        end
        FEED: if (KW'(s.rd_addr) == k_reg - 1'b1) begin
          state <= DRAIN_S;
          s.rd_en <= 1'b0;
          s.rd_addr <= '0;
        end else begin
          s.rd_addr <= s.rd_addr + 1'b1;
        end
        DRAIN_S: if (dcnt == '0) begin
          state <= DONE;
          s.out_valid <= 1'b1;
        end else begin
          dcnt <= dcnt - 1'b1;
        end
        DONE: if (s.out_ready) begin
          state <= IDLE;
          s.out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sa_tile_scheduler.md
SA_TILE_SCHEDULER -- requirements
Module: sa_tile_scheduler

Interface
REQ-001 Parameter CONTEXT_LENGTH, 128, number of X lanes (array rows) feeding the skewed systolic array.
REQ-002 Parameter HIDDEN_SIZE, 64, number of W lanes (array columns) feeding the skewed systolic array.
REQ-003 Parameter MAX_K, 256, maximum inner-dimension length (operand vectors streamed per tile).
REQ-004 Localparam KW = $clog2(MAX_K+1); localparam AW = $clog2(MAX_K); localparam DRAIN = CONTEXT_LENGTH + HIDDEN_SIZE.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  tile request; accepted only when start & start_ready.
REQ-008 k_len  input  KW  inner-dimension length, sampled on accept; legal range 0..MAX_K.
REQ-009 abort  input  1  cancel the current tile.
REQ-010 out_ready  input  1  consumer accepts the completed result.
REQ-011 start_ready  output  1  high only in IDLE.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 sa_clear  output  1  one-cycle pulse that clears array accumulators and skew buffers (drives array rst, ORed with rst externally).
REQ-014 rd_en  output  1  operand memory read enable (X and W memories share the address).
REQ-015 rd_addr  output  AW  operand memory read address.
REQ-016 feed_valid  output  1  rd_en delayed one cycle; gates operand muxes (0 = inject zeros into X_in/W_in).
REQ-017 out_valid  output  1  Y_out of the array is final and stable.

Function
REQ-018 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, DONE, all transitions on the rising clock edge.
REQ-019 IDLE -> CLEAR on accept; k_len latched into k_reg.
REQ-020 CLEAR SHALL last exactly one cycle with sa_clear=1; it goes to FEED if k_reg>0, else to DRAIN.
REQ-021 FEED SHALL last exactly k_reg cycles, with rd_en=1 and rd_addr = 0,1,...,k_reg-1 on successive cycles; then DRAIN.
REQ-022 feed_valid SHALL equal rd_en of the previous cycle, including the cycle after leaving FEED (1-cycle memory latency).
REQ-023 DRAIN SHALL last exactly DRAIN cycles (down-counter), with rd_en=0; then DONE.
REQ-024 DONE SHALL hold out_valid=1 until out_ready=1; on that cycle -> IDLE, and out_valid=0 from the next cycle.
REQ-025 start while not IDLE SHALL be ignored, with no effect on k_reg or the counters.
REQ-026 abort in CLEAR, FEED, DRAIN or DONE SHALL force IDLE next cycle: rd_en, feed_valid, out_valid and sa_clear all 0 next cycle, counters zeroed; abort in IDLE SHALL be a no-op.
REQ-027 When abort and out_ready are both asserted in DONE, the result SHALL be the same as abort alone.
REQ-028 When abort and start are both asserted in IDLE, start SHALL be accepted.
REQ-029 k_len > MAX_K SHALL be saturated to MAX_K on latch.
REQ-030 The address counter SHALL never exceed k_reg-1; no wrap-around is permitted.
REQ-031 All outputs SHALL be registered, except start_ready and busy, which are decoded from the state register.

Reset
REQ-032 While rst=1 the block SHALL enter IDLE with k_reg=0, counters=0, rd_addr=0, rd_en=0, feed_valid=0, sa_clear=0, out_valid=0, so start_ready=1 and busy=0.
REQ-033 rst asserted in any state SHALL take effect on the next edge and override start and abort.

Verification (CONTEXT_LENGTH=4, HIDDEN_SIZE=4, DRAIN=8; start accepted at cycle 0)
REQ-034 k_len=3 -> sa_clear=1 at cycle 1; rd_en=1 at cycles 2-4 with rd_addr 0,1,2; feed_valid=1 at cycles 3-5; out_valid=1 from cycle 13.
REQ-035 k_len=3, out_ready held 0 until cycle 20 -> out_valid stays 1 over cycles 13-20, 0 at cycle 21, start_ready=1 at cycle 21.
REQ-036 k_len=0 -> CLEAR at cycle 1, no rd_en, out_valid=1 from cycle 10.
REQ-037 abort at cycle 3 (FEED) -> cycle 4: rd_en=0, busy=0; feed_valid=0 at cycle 5; a new start at cycle 4 is accepted.
REQ-038 start re-pulsed at cycles 2 and 7 with k_len=5 -> ignored; tile completes with 3 reads, per the REQ-034 timing.
REQ-039 rst at cycle 6 (DRAIN) -> cycle 7: all outputs at reset values, start_ready=1.
